if_pipe_ctrl: RTL and testbench

IF_PIPE_CTRL -- requirements
Module: if_pipe_ctrl

---
 rtl/if_pipe_pkg.sv | 16 +
 rtl/if_hazard_detect.sv | 25 ++
 rtl/if_pipe_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_if_pipe_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pipe_pkg.sv
// Shared types and constants for the instruction-fetch pipeline control.
// Optional perf counters in the top are enabled by IF_PIPE_CTRL_PERF_EN.
package if_pipe_pkg;

    localparam int REG_ADDR_W = 4;
    localparam int PC_W       = 16;

    localparam logic [PC_W-1:0] NOP = 16'h0000;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_FLUSH,
        ST_WAIT
    } state_t;

endpackage

// File: rtl/if_hazard_detect.sv
// Load-use hazard detect between the instruction in ID and a load in EX.
// Purely combinational.
module if_hazard_detect
    import if_pipe_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic                  ex_is_load,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  hazard
);

    logic hit1;
    logic hit2;

    // r0 is never written, so a load to r0 cannot create a dependency
    always_comb begin
        hit1   = id_uses_rs1 && (id_rs1 == ex_rd);
        hit2   = id_uses_rs2 && (id_rs2 == ex_rd);
        hazard = ex_is_load && (ex_rd != '0) && (hit1 || hit2);
    end

endmodule

// File: rtl/if_pipe_ctrl.sv
// Fetch/decode pipeline controller: redirect flush, load-use stall, imem wait.
// Define IF_PIPE_CTRL_PERF_EN to add stall_cnt/flush_cnt counters.
module if_pipe_ctrl
    import if_pipe_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int WAIT_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic                  ex_is_load,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  branch_taken,
    input  logic [PC_W-1:0]       branch_target,
    input  logic                  imem_busy,
    output logic                  pc_we,
    output logic                  pc_sel,
    output logic [PC_W-1:0]       pc_redirect,
    output logic                  ifid_we,
    output logic                  ifid_flush,
    output logic                  idex_bubble,
    output logic                  wait_err
`ifdef IF_PIPE_CTRL_PERF_EN
    ,
    output logic [15:0]           stall_cnt,
    output logic [15:0]           flush_cnt
`endif
);

    state_t          state;
    state_t          state_n;
    logic [2:0]      fcnt;
    logic [2:0]      fcnt_n;
    logic [15:0]     wcnt;
    logic [15:0]     wcnt_n;
    logic            pend;
    logic            pend_n;
    logic [PC_W-1:0] ptgt;
    logic [PC_W-1:0] ptgt_n;
    logic            err_n;

    logic            hazard;
    logic            redir;
    logic [PC_W-1:0] rtgt;

    logic            r_pc_we;
    logic            r_pc_sel;
    logic [PC_W-1:0] r_redirect;
    logic            r_ifid_we;
    logic            r_flush;
    logic            r_bubble;

    if_hazard_detect u_hazard (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_is_load  (ex_is_load),
        .ex_rd       (ex_rd),
        .hazard      (hazard)
    );

    // State, counters, pending redirect and sticky timeout flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_RUN;
            fcnt     <= '0;
            wcnt     <= '0;
            pend     <= 1'b0;
            ptgt     <= NOP;
            wait_err <= 1'b0;
        end else begin
            state    <= state_n;
            fcnt     <= fcnt_n;
            wcnt     <= wcnt_n;
            pend     <= pend_n;
            ptgt     <= ptgt_n;
            wait_err <= err_n;
        end
    end

    // Next state and raw control outputs from state and live inputs
    always_comb begin
        state_n    = state;
        fcnt_n     = fcnt;
        wcnt_n     = wcnt;
        pend_n     = pend;
        ptgt_n     = ptgt;
        err_n      = wait_err;
        redir      = 1'b0;
        rtgt       = NOP;
        r_pc_we    = 1'b0;
        r_pc_sel   = 1'b0;
        r_redirect = NOP;
        r_ifid_we  = 1'b0;
        r_flush    = 1'b0;
        r_bubble   = 1'b0;

        unique case (state)
            ST_RUN: begin
                if (branch_taken) begin
                    redir = 1'b1;
                    rtgt  = branch_target;
                end else if (imem_busy) begin
                    r_bubble = 1'b1;
                    state_n  = ST_WAIT;
                    wcnt_n   = '0;
                end else if (hazard) begin
                    r_bubble = 1'b1;
                end else begin
                    r_pc_we   = 1'b1;
                    r_ifid_we = 1'b1;
                end
            end
            ST_FLUSH: begin
                // wrong-path branches are ignored here
                r_pc_we   = 1'b1;
                r_ifid_we = 1'b1;
                r_flush   = 1'b1;
                r_bubble  = 1'b1;
                fcnt_n    = fcnt - 3'd1;
                if (fcnt_n == '0) begin
                    state_n = imem_busy ? ST_WAIT : ST_RUN;
                    wcnt_n  = '0;
                end
            end
            ST_WAIT: begin
                if (imem_busy) begin
                    r_bubble = 1'b1;
                    if (branch_taken) begin
                        pend_n = 1'b1;
                        ptgt_n = branch_target;
                    end
                    if (wcnt != 16'hFFFF) begin
                        wcnt_n = wcnt + 16'd1;
                    end
                    if (wcnt_n == 16'(WAIT_TIMEOUT)) begin
                        err_n = 1'b1;
                    end
                end else begin
                    // a branch seen on the release cycle is the newest one
                    pend_n  = 1'b0;
                    state_n = ST_RUN;
                    if (branch_taken) begin
                        redir = 1'b1;
                        rtgt  = branch_target;
                    end else if (pend) begin
                        redir = 1'b1;
                        rtgt  = ptgt;
                    end else begin
                        r_pc_we   = 1'b1;
                        r_ifid_we = 1'b1;
                    end
                end
            end
            default: begin
                state_n = ST_RUN;
            end
        endcase

        if (redir) begin
            r_pc_we    = 1'b1;
            r_pc_sel   = 1'b1;
            r_redirect = rtgt;
            r_ifid_we  = 1'b1;
            r_flush    = 1'b1;
            r_bubble   = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_n = ST_FLUSH;
                fcnt_n  = 3'(FLUSH_CYCLES - 1);
            end else begin
                state_n = ST_RUN;
                fcnt_n  = '0;
            end
        end
    end

    // Reset holds every control output inactive
    always_comb begin
        pc_we       = r_pc_we   && reset_n;
        pc_sel      = r_pc_sel  && reset_n;
        ifid_we     = r_ifid_we && reset_n;
        ifid_flush  = r_flush   && reset_n;
        idex_bubble = r_bubble  && reset_n;
        pc_redirect = reset_n ? r_redirect : NOP;
    end

`ifdef IF_PIPE_CTRL_PERF_EN
    // Saturating counts of bubble and flush cycles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (idex_bubble && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (ifid_flush && flush_cnt != 16'hFFFF) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_pipe_ctrl.sv
// Directed and random bench for if_pipe_ctrl against a behavioural model.
// Covers perf counters when IF_PIPE_CTRL_PERF_EN is defined.
module tb_if_pipe_ctrl;

    localparam int FC = 3;
    localparam int TO = 5;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  id_rs1, id_rs2, ex_rd;
    logic        id_uses_rs1, id_uses_rs2, ex_is_load;
    logic        branch_taken, imem_busy;
    logic [15:0] branch_target;
    logic        pc_we, pc_sel, ifid_we, ifid_flush, idex_bubble;
    logic        wait_err;
    logic [15:0] pc_redirect;
`ifdef IF_PIPE_CTRL_PERF_EN
    logic [15:0] stall_cnt, flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // model: flush cycles left, waiting flag, wait count, pending branch
    int          m_fl;
    bit          m_wt;
    int          m_wc;
    bit          m_pd;
    logic [15:0] m_pt;
    bit          m_er;
    int          m_sc;
    int          m_fc;

    if_pipe_ctrl #(
        .FLUSH_CYCLES (FC),
        .WAIT_TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_uses_rs1   (id_uses_rs1),
        .id_uses_rs2   (id_uses_rs2),
        .ex_is_load    (ex_is_load),
        .ex_rd         (ex_rd),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_busy     (imem_busy),
        .pc_we         (pc_we),
        .pc_sel        (pc_sel),
        .pc_redirect   (pc_redirect),
        .ifid_we       (ifid_we),
        .ifid_flush    (ifid_flush),
        .idex_bubble   (idex_bubble),
        .wait_err      (wait_err)
`ifdef IF_PIPE_CTRL_PERF_EN
        ,
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [15:0] got,
                       input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_fl = 0; m_wt = 0; m_wc = 0;
        m_pd = 0; m_pt = 16'h0; m_er = 0;
        m_sc = 0; m_fc = 0;
    endtask

    task automatic idle();
        id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
        id_uses_rs1 = 0; id_uses_rs2 = 0;
        ex_is_load = 0; branch_taken = 0;
        branch_target = 0; imem_busy = 0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_pc_we"}, 16'(pc_we), 16'h0);
        chk({tag, "_pc_sel"}, 16'(pc_sel), 16'h0);
        chk({tag, "_redir"}, pc_redirect, 16'h0);
        chk({tag, "_ifid_we"}, 16'(ifid_we), 16'h0);
        chk({tag, "_flush"}, 16'(ifid_flush), 16'h0);
        chk({tag, "_bubble"}, 16'(idex_bubble), 16'h0);
    endtask

    // called at posedge+1 with inputs set; returns at next posedge+1
    task automatic step(input string tag);
        bit hz, go;
        logic [15:0] rt;
        bit e_we, e_sel, e_ifwe, e_fl, e_bub;
        logic [15:0] e_red;
        int n_fl, n_wc;
        bit n_wt, n_pd, n_er;
        logic [15:0] n_pt;
        n_fl = m_fl; n_wt = m_wt; n_wc = m_wc;
        n_pd = m_pd; n_pt = m_pt; n_er = m_er;
        e_we = 0; e_sel = 0; e_ifwe = 0;
        e_fl = 0; e_bub = 0; e_red = 0;
        go = 0; rt = 0;
        #2;
        hz = ex_is_load && ex_rd != 0 &&
             ((id_uses_rs1 && id_rs1 == ex_rd) ||
              (id_uses_rs2 && id_rs2 == ex_rd));
        if (m_fl > 0) begin
            e_we = 1; e_ifwe = 1; e_fl = 1; e_bub = 1;
            n_fl = m_fl - 1;
            if (n_fl == 0 && imem_busy) begin
                n_wt = 1; n_wc = 0;
            end
        end else if (m_wt) begin
            if (imem_busy) begin
                e_bub = 1;
                if (branch_taken) begin
                    n_pd = 1; n_pt = branch_target;
                end
                n_wc = (m_wc < 65535) ? m_wc + 1 : m_wc;
                if (n_wc == TO) n_er = 1;
            end else begin
                n_wt = 0; n_pd = 0;
                if (branch_taken) begin
                    go = 1; rt = branch_target;
                end else if (m_pd) begin
                    go = 1; rt = m_pt;
                end else begin
                    e_we = 1; e_ifwe = 1;
                end
            end
        end else begin
            if (branch_taken) begin
                go = 1; rt = branch_target;
            end else if (imem_busy) begin
                e_bub = 1; n_wt = 1; n_wc = 0;
            end else if (hz) begin
                e_bub = 1;
            end else begin
                e_we = 1; e_ifwe = 1;
            end
        end
        if (go) begin
            e_we = 1; e_sel = 1; e_red = rt;
            e_ifwe = 1; e_fl = 1; e_bub = 1;
            n_fl = FC - 1;
        end
        chk({tag, "_pc_we"}, 16'(pc_we), 16'(e_we));
        chk({tag, "_pc_sel"}, 16'(pc_sel), 16'(e_sel));
        chk({tag, "_redir"}, pc_redirect, e_red);
        chk({tag, "_ifid_we"}, 16'(ifid_we), 16'(e_ifwe));
        chk({tag, "_flush"}, 16'(ifid_flush), 16'(e_fl));
        chk({tag, "_bubble"}, 16'(idex_bubble), 16'(e_bub));
        chk({tag, "_err"}, 16'(wait_err), 16'(m_er));
`ifdef IF_PIPE_CTRL_PERF_EN
        chk({tag, "_stall_cnt"}, stall_cnt, 16'(m_sc));
        chk({tag, "_flush_cnt"}, flush_cnt, 16'(m_fc));
`endif
        @(posedge clk);
        m_fl = n_fl; m_wt = n_wt; m_wc = n_wc;
        m_pd = n_pd; m_pt = n_pt; m_er = n_er;
        if (e_bub && m_sc < 65535) m_sc++;
        if (e_fl && m_fc < 65535) m_fc++;
        #1;
    endtask

    initial begin
        idle();
        model_reset();
        reset_n = 1'b0;
        branch_taken = 1; branch_target = 16'h1234;
        #1;
        chk_zero("rst_init");
        @(posedge clk);
        @(posedge clk);
        #1;
        idle();
        reset_n = 1'b1;

        step("normal0");
        // load-use hazard on rs1
        ex_is_load = 1; ex_rd = 3;
        id_rs1 = 3; id_uses_rs1 = 1;
        step("hz_rs1");
        idle();
        step("hz_after");
        // load to r0 never stalls
        ex_is_load = 1; ex_rd = 0;
        id_rs1 = 0; id_uses_rs1 = 1;
        step("hz_r0");
        idle();
        // hazard via rs2, rs1 unqualified
        ex_is_load = 1; ex_rd = 7;
        id_rs1 = 7; id_rs2 = 7; id_uses_rs2 = 1;
        step("hz_rs2");
        idle();

        // taken branch with a wrong-path branch in cycle 2
        branch_taken = 1; branch_target = 16'h0040;
        step("br_det");
        branch_taken = 1; branch_target = 16'h0999;
        step("br_f2");
        idle();
        step("br_f3");
        step("br_done");

        // imem wait with branch latched in wait cycle 2
        imem_busy = 1;
        step("mw1");
        branch_taken = 1; branch_target = 16'h0100;
        step("mw2");
        branch_taken = 0;
        step("mw3");
        step("mw4");
        imem_busy = 0;
        #2;
        chk("mw_rel_sel", 16'(pc_sel), 16'h1);
        chk("mw_rel_redir", pc_redirect, 16'h0100);
        step("mw_rel");
        step("mw_f2");
        step("mw_f3");
        step("mw_done");

        // timeout after five wait cycles, sticky after release
        imem_busy = 1;
        for (int i = 0; i < 10; i++) step("to_busy");
        chk("to_err_set", 16'(wait_err), 16'h1);
        imem_busy = 0;
        step("to_rel");
        step("to_post");
        chk("to_err_sticky", 16'(wait_err), 16'h1);

        // reset in mid wait with a pending branch
        imem_busy = 1;
        step("rw1");
        branch_taken = 1; branch_target = 16'h0ABC;
        step("rw2");
        branch_taken = 0; imem_busy = 0;
        #2;
        reset_n = 1'b0;
        #1;
        chk_zero("rst_mid");
        chk("rst_err", 16'(wait_err), 16'h0);
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step("rst_after");
        step("rst_after2");

        // random traffic
        for (int i = 0; i < 600; i++) begin
            branch_taken  = ($urandom_range(0, 7) == 0);
            branch_target = 16'($urandom);
            if ($urandom_range(0, 9) == 0)
                imem_busy = ~imem_busy;
            else if (imem_busy && $urandom_range(0, 3) == 0)
                imem_busy = 0;
            ex_is_load  = $urandom_range(0, 1) == 1;
            ex_rd       = 4'($urandom_range(0, 3));
            id_rs1      = 4'($urandom_range(0, 3));
            id_rs2      = 4'($urandom_range(0, 3));
            id_uses_rs1 = $urandom_range(0, 1) == 1;
            id_uses_rs2 = $urandom_range(0, 1) == 1;
            step("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
